// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and constants for the load-use hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   // Register address width of the host pipeline.
   localparam int SB_REG_AW = 5;

   typedef logic [SB_REG_AW-1:0] reg_addr_t;

   // One in-flight load tracked by the scoreboard.
   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
   } sb_entry_t;

   // Architectural zero register: never produces a hazard.
   localparam reg_addr_t ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_sb_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sb_match
// Brief    : Compares one scoreboard entry against the rs/rt operands of the
//            instruction in ID. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_sb_match
   import hazard_pkg::*;
#(
   parameter int REG_AW = SB_REG_AW
) (
   input  logic              valid,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic              rs_used,
   input  logic              rt_used,
   output logic              hit
);

   localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

   logic rd_live;
   logic rs_match;
   logic rt_match;

   // A load writing the zero register produces nothing to wait for.
   assign rd_live  = valid && (rd != ZERO_ADDR);
   assign rs_match = rs_used && (rd == rs);
   assign rt_match = rt_used && (rd == rt);
   assign hit      = rd_live && (rs_match || rt_match);

endmodule
`default_nettype wire

// File: rtl/hazard_unit_sb.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_sb
// Brief    : Load-use hazard unit with a LOAD_LAT-deep shift scoreboard of
//            in-flight loads, taken-branch flush and data-memory freeze.
//            Optional macro HAZARD_PERF_EN adds a saturating stall counter;
//            without it stall_cnt_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_sb
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] ifid_rs_i,
   input  logic [REG_AW-1:0] ifid_rt_i,
   input  logic              ifid_rs_used_i,
   input  logic              ifid_rt_used_i,
   input  logic              ifid_valid_i,
   input  logic              ifid_memread_i,
   input  logic [REG_AW-1:0] ifid_rd_i,
   input  logic              branch_taken_i,
   input  logic              dmem_busy_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              ctrl_sel_o,
   output logic              ifid_flush_o,
   output logic              pipe_hold_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   // Entry k describes the load currently sitting in EX+k.
   logic [LOAD_LAT-1:0] sb_valid;
   logic [REG_AW-1:0]   sb_rd [LOAD_LAT];
   logic [LOAD_LAT-1:0] entry_hit;

   logic hit;
   logic freeze;
   logic flush;
   logic stall;
   logic load_issue;

   for (genvar k = 0; k < LOAD_LAT; k++) begin : g_match
      hazard_sb_match #(
         .REG_AW (REG_AW)
      ) u_match (
         .valid   (sb_valid[k]),
         .rd      (sb_rd[k]),
         .rs      (ifid_rs_i),
         .rt      (ifid_rt_i),
         .rs_used (ifid_rs_used_i),
         .rt_used (ifid_rt_used_i),
         .hit     (entry_hit[k])
      );
   end

   assign hit    = |entry_hit;
   assign freeze = dmem_busy_i;
   assign flush  = branch_taken_i && !freeze;
   assign stall  = hit && !freeze && !flush;

   // A stalled or squashed load stays out of the scoreboard; it is
   // re-evaluated (or discarded) while it still sits in ID.
   assign load_issue = ifid_valid_i && ifid_memread_i && !hit && !branch_taken_i;

   // Pipeline control decode: freeze beats flush, flush beats stall.
   always_comb begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ctrl_sel_o   = 1'b0;
      ifid_flush_o = 1'b0;
      pipe_hold_o  = 1'b0;
      if (freeze) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         pipe_hold_o  = 1'b1;
      end else if (flush) begin
         ifid_flush_o = 1'b1;
         ctrl_sel_o   = 1'b1;
      end else if (stall) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         ctrl_sel_o   = 1'b1;
      end
   end

   // Scoreboard shift: advances one stage on every edge not frozen by memory.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sb_valid <= '0;
         for (int k = 0; k < LOAD_LAT; k++) begin
            sb_rd[k] <= '0;
         end
      end else if (!freeze) begin
         sb_valid[0] <= load_issue;
         sb_rd[0]    <= ifid_rd_i;
         for (int k = 1; k < LOAD_LAT; k++) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_rd[k]    <= sb_rd[k-1];
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt;

   // Saturating count of load-use stall cycles (freeze/flush excluded).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_sb
// Brief    : Self-checking bench: three hazard units (LOAD_LAT = 1, 2, 3,
//            CNT_W = 2) share one stimulus stream and are checked against a
//            ready-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_sb;

   localparam int ND = 3;
`ifdef HAZARD_PERF_EN
   localparam int CNT_MAX = 3;
`else
   localparam int CNT_MAX = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs, rt, rd;
   logic       rs_used, rt_used, valid, memread, br, busy;

   logic       pc_w  [ND];
   logic       ifid_w[ND];
   logic       ctrl  [ND];
   logic       flsh  [ND];
   logic       hold  [ND];
   logic [1:0] cnt_o [ND];

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // Reference model: per register, the model tick from which a pending load
   // result is forwardable; ticks advance only on non-frozen edges.
   int ready_at [ND][32];
   int tick     [ND];
   int mcnt     [ND];
   int seen     [ND];

   always #5 clk = ~clk;

   for (genvar d = 0; d < ND; d++) begin : g_dut
      hazard_unit_sb #(
         .REG_AW   (5),
         .LOAD_LAT (d + 1),
         .CNT_W    (2)
      ) u_dut (
         .clk_i          (clk),
         .rst_i          (rst),
         .ifid_rs_i      (rs),
         .ifid_rt_i      (rt),
         .ifid_rs_used_i (rs_used),
         .ifid_rt_used_i (rt_used),
         .ifid_valid_i   (valid),
         .ifid_memread_i (memread),
         .ifid_rd_i      (rd),
         .branch_taken_i (br),
         .dmem_busy_i    (busy),
         .pc_write_o     (pc_w[d]),
         .ifid_write_o   (ifid_w[d]),
         .ctrl_sel_o     (ctrl[d]),
         .ifid_flush_o   (flsh[d]),
         .pipe_hold_o    (hold[d]),
         .stall_cnt_o    (cnt_o[d])
      );
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit mhit(int d);
      bit h = 1'b0;
      if (rs_used && rs != 0 && ready_at[d][rs] > tick[d]) h = 1'b1;
      if (rt_used && rt != 0 && ready_at[d][rt] > tick[d]) h = 1'b1;
      return h;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < ND; d++) begin
         for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
         mcnt[d] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int d = 0; d < ND; d++) begin
         bit h, fz, fl, st;
         h  = mhit(d);
         fz = busy;
         fl = br && !busy;
         st = h && !fz && !fl;
         chk($sformatf("%s/L%0d pc_write", tag, d + 1), 8'(pc_w[d]), 8'(!fz && (fl || !st)));
         if (!fl)
            chk($sformatf("%s/L%0d ifid_write", tag, d + 1), 8'(ifid_w[d]), 8'(!fz && !st));
         chk($sformatf("%s/L%0d ctrl_sel", tag, d + 1), 8'(ctrl[d]), 8'(fl || st));
         chk($sformatf("%s/L%0d ifid_flush", tag, d + 1), 8'(flsh[d]), 8'(fl));
         chk($sformatf("%s/L%0d pipe_hold", tag, d + 1), 8'(hold[d]), 8'(fz));
         chk($sformatf("%s/L%0d stall_cnt", tag, d + 1), 8'(cnt_o[d]), 8'(mcnt[d]));
         if (!pc_w[d] && !fz) seen[d]++;
      end
   endtask

   task automatic update_model();
      for (int d = 0; d < ND; d++) begin
         if (!busy) begin
            bit h;
            h = mhit(d);
            if (h && !br && mcnt[d] < CNT_MAX) mcnt[d]++;
            if (valid && memread && !h && !br) ready_at[d][rd] = tick[d] + d + 2;
            tick[d]++;
         end
      end
   endtask

   task automatic step(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   task automatic set_id(input bit v, input bit mr, input int drd,
                         input int s, input bit su, input int t, input bit tu);
      valid = v; memread = mr; rd = 5'(drd);
      rs = 5'(s); rs_used = su; rt = 5'(t); rt_used = tu;
   endtask

   // Hold the current ID instruction for n cycles; each unit should stall
   // max(LOAD_LAT - off, 0) of them.
   task automatic hold_count(input string tag, input int n, input int off);
      for (int d = 0; d < ND; d++) seen[d] = 0;
      repeat (n) step(tag);
      for (int d = 0; d < ND; d++)
         chk($sformatf("%s/L%0d stall_len", tag, d + 1), 8'(seen[d]),
             8'((d + 1 - off) > 0 ? (d + 1 - off) : 0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; br = 1'b0; busy = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0);
      for (int d = 0; d < ND; d++) tick[d] = 0;
      model_clear();
      #2 check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Classic load-use: load rd=5 then consumer of rs=5.
      set_id(1, 1, 5, 0, 0, 0, 0); step("a_load");
      set_id(1, 0, 0, 5, 1, 0, 0); hold_count("a_use", 5, 0);

      // Consumer directly behind the load, then with one independent gap.
      set_id(1, 1, 7, 0, 0, 0, 0); step("b_load");
      set_id(1, 0, 0, 0, 0, 7, 1); hold_count("b_use", 5, 0);
      set_id(1, 1, 7, 0, 0, 0, 0); step("b2_load");
      set_id(1, 0, 0, 3, 1, 0, 0); step("b2_gap");
      set_id(1, 0, 0, 0, 0, 7, 1); hold_count("b2_use", 5, 1);

      // Zero register and unused operand never stall.
      set_id(1, 1, 0, 0, 0, 0, 0); step("z_load");
      set_id(1, 0, 0, 0, 1, 0, 0); hold_count("z_use", 4, 9);
      set_id(1, 1, 9, 0, 0, 0, 0); step("u_load");
      set_id(1, 0, 0, 9, 0, 1, 1); hold_count("u_use", 4, 9);

      // Branch taken in the first stall cycle; the load in ID is dropped.
      set_id(1, 1, 4, 0, 0, 0, 0); step("f_load");
      set_id(1, 1, 8, 4, 1, 0, 0); br = 1'b1; step("f_flush");
      br = 1'b0;
      set_id(1, 0, 0, 8, 1, 0, 0); hold_count("f_after", 4, 9);

      // Freeze for two cycles in the middle of a stall.
      set_id(1, 1, 6, 0, 0, 0, 0); step("h_load");
      set_id(1, 0, 0, 6, 1, 0, 0); step("h_stall1");
      busy = 1'b1; step("h_frz1"); step("h_frz2");
      busy = 1'b0; hold_count("h_rest", 5, 1);

      // Asynchronous reset in the middle of a stall.
      set_id(1, 1, 2, 0, 0, 0, 0); step("r_load");
      set_id(1, 0, 0, 2, 1, 0, 0);
      #1 check_all("r_stall");
      #2 rst = 1'b1;
      model_clear();
      #1 check_all("r_async");
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("r_rel/L%0d pc_write", d + 1), 8'(pc_w[d]), 8'd1);
         chk($sformatf("r_rel/L%0d ctrl_sel", d + 1), 8'(ctrl[d]), 8'd0);
      end
      #1 rst = 1'b0;
      @(posedge clk); update_model(); @(negedge clk);
      step("r_after");

      // Randomised traffic on a small register window to provoke hazards.
      for (int i = 0; i < 300; i++) begin
         valid   = ($urandom_range(0, 7) != 0);
         memread = ($urandom_range(0, 1) == 1);
         rd      = 5'($urandom_range(0, 7));
         rs      = 5'($urandom_range(0, 7));
         rt      = 5'($urandom_range(0, 7));
         rs_used = ($urandom_range(0, 3) != 0);
         rt_used = ($urandom_range(0, 1) == 1);
         br      = ($urandom_range(0, 7) == 0);
         busy    = ($urandom_range(0, 7) == 0);
         step("rand");
      end

      // Counter saturation: 2*LOAD_LAT stall cycles after a clean reset.
      br = 1'b0; busy = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1; model_clear();
      #2 rst = 1'b0;
      @(negedge clk);
      set_id(1, 1, 3, 0, 0, 0, 0); step("s_load1");
      set_id(1, 0, 0, 3, 1, 0, 0); hold_count("s_use1", 4, 0);
      set_id(1, 1, 3, 0, 0, 0, 0); step("s_load2");
      set_id(1, 0, 0, 3, 1, 0, 0); hold_count("s_use2", 4, 0);
      #1;
      for (int d = 0; d < ND; d++) begin
         int n;
         n = 2 * (d + 1);
         chk($sformatf("s_sat/L%0d stall_cnt", d + 1), 8'(cnt_o[d]),
             8'(n < CNT_MAX ? n : CNT_MAX));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
